// File: rtl/decoder_nx2pn_pulse_pkg.sv
// Shared types and helpers for the pulsed N-to-2**N one-hot decoder.
package decoder_nx2pn_pulse_pkg;

    localparam int unsigned MAX_N   = 10;
    localparam int unsigned MAX_OUT = 1 << MAX_N;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Returns 1<<idx, or zero when idx does not fit in an n-bit index.
    function automatic logic [MAX_OUT-1:0] onehot_of(input int unsigned idx, input int unsigned n);
        logic [MAX_OUT-1:0] r;
        r = '0;
        if (n <= MAX_N && idx < (32'd1 << n)) begin
            r = MAX_OUT'(1) << idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_nx2pn_pulse_dec.sv
// Purely combinational N-to-2**N one-hot decoder.
module decoder_nx2pn
    import decoder_nx2pn_pulse_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]        idx,
    output logic [(1<<N)-1:0]   onehot
);

    localparam int unsigned W = 1 << N;

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < W; i++) begin
            onehot[i] = |(onehot_of(32'(idx), N) & (MAX_OUT'(1) << i));
        end
    end

endmodule

// File: rtl/decoder_nx2pn_pulse.sv
// Sequential one-hot decoder: each accepted index drives its output line for
// PULSE_LEN cycles; a one-entry pending buffer chains pulses without a gap.
module decoder_nx2pn_pulse
    import decoder_nx2pn_pulse_pkg::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned PULSE_LEN = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [N-1:0]        IN,
    output logic [(1<<N)-1:0]   OUT,
    output logic                OUT_ACTIVE,
    output logic                DONE
);

    localparam int unsigned   CW       = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                pend_v;
    logic [N-1:0]        pend_idx;
    logic [N-1:0]        dec_idx;
    logic [(1<<N)-1:0]   dec_out;
    logic                accept;
    logic                last;

    assign IN_READY   = !RST && !pend_v;
    assign accept     = IN_VALID && IN_READY;
    assign last       = (state == ACTIVE) && (cnt == '0);
    assign DONE       = last;
    assign OUT_ACTIVE = |OUT;

    // The pending entry always wins at a pulse boundary; IN_READY is low then.
    assign dec_idx = pend_v ? pend_idx : IN;

    decoder_nx2pn #(.N(N)) u_dec (
        .idx    (dec_idx),
        .onehot (dec_out)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_v   <= 1'b0;
            pend_idx <= '0;
            OUT      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        OUT   <= dec_out;
                        cnt   <= CNT_LOAD;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (accept) begin
                            pend_v   <= 1'b1;
                            pend_idx <= IN;
                        end
                    end else if (pend_v) begin
                        OUT    <= dec_out;
                        pend_v <= 1'b0;
                        cnt    <= CNT_LOAD;
                    end else if (accept) begin
                        OUT <= dec_out;
                        cnt <= CNT_LOAD;
                    end else begin
                        OUT   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    OUT   <= '0;
                end
            endcase
        end
    end

    a_active_onehot: assert property (@(posedge CLK) disable iff (RST)
        (state == ACTIVE) |-> $onehot(OUT));
    a_idle_zero: assert property (@(posedge CLK) disable iff (RST)
        (state == IDLE) |-> (OUT == '0));

endmodule
